// File: rtl/seg7_pkg.sv
// ---------------------------------------------------------------------------
// seg7_pkg
// Shared definitions for the BCD seven-segment scanner.
//   - NUM_DIGITS : number of display positions (fixed at 5)
//   - bcd_t      : 4-bit BCD digit type
//   - SEG_*      : active-low segment patterns, bit order {g,f,e,d,c,b,a}
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

package seg7_pkg;

  localparam int NUM_DIGITS = 5;

  typedef logic [3:0] bcd_t;

  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

endpackage

// File: rtl/bcd_seg7_decode.sv
// ---------------------------------------------------------------------------
// bcd_seg7_decode
// Purely combinational BCD to seven-segment decoder, active-low outputs.
// Codes 10..15 are not valid BCD and are shown as a dash so that a
// corrupted digit is visible on the display instead of silently wrong.
// Ports:
//   digit : in  bcd_t       BCD digit to display
//   seg   : out logic [6:0] segments {g,f,e,d,c,b,a}, active-low
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module bcd_seg7_decode
  import seg7_pkg::*;
(
  input  bcd_t       digit,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_DASH;
    case (digit)
      4'd0: seg = SEG_0;
      4'd1: seg = SEG_1;
      4'd2: seg = SEG_2;
      4'd3: seg = SEG_3;
      4'd4: seg = SEG_4;
      4'd5: seg = SEG_5;
      4'd6: seg = SEG_6;
      4'd7: seg = SEG_7;
      4'd8: seg = SEG_8;
      4'd9: seg = SEG_9;
      default: seg = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/bcd_seg7_scanner.sv
// ---------------------------------------------------------------------------
// bcd_seg7_scanner
// Time-multiplexed driver for a 5-digit common-anode seven-segment display.
// A prescaler divides clk down to one scan slot per REFRESH_DIV cycles; each
// slot lights one position. The five input digits are captured into shadow
// registers once per frame (on the wrap from the last position back to the
// first) so a single frame never mixes old and new values.
//
// Optional build macro:
//   SEG_LZB_EN : leading-zero blanking. Positions 4..1 go blank when their
//                shadow digit and every higher digit are zero. Position 0 is
//                never blanked. Invalid codes count as non-zero.
//
// Parameters:
//   REFRESH_DIV : clk cycles per digit slot (>= 2)
// Ports:
//   clk        : in  system clock, rising edge
//   rst_n      : in  asynchronous active-low reset
//   D5..D1     : in  BCD digits, D5 = ten-thousands, D1 = units
//   enable     : in  low blanks the whole display; scanning continues
//   an         : out anode selects, active-low, an[0] = D1 position
//   seg        : out segments {g,f,e,d,c,b,a}, active-low
//   frame_done : out one-cycle pulse following each shadow load
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module bcd_seg7_scanner
  import seg7_pkg::*;
#(
  parameter int REFRESH_DIV = 50000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] D5,
  input  logic [3:0] D4,
  input  logic [3:0] D3,
  input  logic [3:0] D2,
  input  logic [3:0] D1,
  input  logic       enable,
  output logic [4:0] an,
  output logic [6:0] seg,
  output logic       frame_done
);

  localparam int            PW        = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(REFRESH_DIV - 1);
  localparam logic [2:0]    IDX_MAX   = 3'(NUM_DIGITS - 1);

  logic [PW-1:0]              presc;
  logic                       tick;
  logic [2:0]                 idx;
  bcd_t [NUM_DIGITS-1:0]      shadow;
  bcd_t                       cur_digit;
  logic                       cur_blank;
  logic [4:0]                 cur_an;
  logic [6:0]                 dec_seg;
  logic [NUM_DIGITS-1:1]      lead_zero;

  assign tick = (presc == PRESC_MAX);

  // Slot prescaler and scan position.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc <= '0;
      idx   <= '0;
    end else begin
      if (tick) begin
        presc <= '0;
        idx   <= (idx == IDX_MAX) ? 3'd0 : idx + 3'd1;
      end else begin
        presc <= presc + 1'b1;
      end
    end
  end

  // The shadow load happens on the same edge that wraps idx back to 0, so
  // the new frame starts with freshly captured digits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow     <= '0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      if (tick && (idx == IDX_MAX)) begin
        shadow     <= {D5, D4, D3, D2, D1};
        frame_done <= 1'b1;
      end
    end
  end

  // lead_zero[k]: shadow digits k..4 are all zero, so position k is a
  // leading zero. Written as OR-reductions to keep each bit independent.
`ifdef SEG_LZB_EN
  assign lead_zero[4] = (shadow[4] == 4'd0);
  assign lead_zero[3] = ((shadow[4] | shadow[3]) == 4'd0);
  assign lead_zero[2] = ((shadow[4] | shadow[3] | shadow[2]) == 4'd0);
  assign lead_zero[1] = ((shadow[4] | shadow[3] | shadow[2] | shadow[1]) == 4'd0);
`else
  assign lead_zero = '0;
`endif

  always_comb begin
    cur_digit = shadow[0];
    cur_blank = 1'b0;
    cur_an    = 5'b11110;
    case (idx)
      3'd1: begin
        cur_digit = shadow[1];
        cur_blank = lead_zero[1];
        cur_an    = 5'b11101;
      end
      3'd2: begin
        cur_digit = shadow[2];
        cur_blank = lead_zero[2];
        cur_an    = 5'b11011;
      end
      3'd3: begin
        cur_digit = shadow[3];
        cur_blank = lead_zero[3];
        cur_an    = 5'b10111;
      end
      3'd4: begin
        cur_digit = shadow[4];
        cur_blank = lead_zero[4];
        cur_an    = 5'b01111;
      end
      default: begin
        cur_digit = shadow[0];
        cur_blank = 1'b0;
        cur_an    = 5'b11110;
      end
    endcase
  end

  bcd_seg7_decode u_decode (
    .digit (cur_digit),
    .seg   (dec_seg)
  );

  // Registered pin drivers. A blanked leading zero keeps its anode active
  // so the scan duty cycle stays uniform across positions.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      an  <= 5'b11111;
      seg <= SEG_BLANK;
    end else if (!enable) begin
      an  <= 5'b11111;
      seg <= SEG_BLANK;
    end else begin
      an  <= cur_an;
      seg <= cur_blank ? SEG_BLANK : dec_seg;
    end
  end

endmodule

// File: tb/tb_bcd_seg7_scanner.sv
// ---------------------------------------------------------------------------
// tb_bcd_seg7_scanner
// Scoreboard bench for bcd_seg7_scanner with REFRESH_DIV = 4 (20-cycle
// frames). The stimulus task pushes the five expected slot values of a
// frame when that frame's shadow load is seen; a monitor process pops and
// compares them at the middle of each slot.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_bcd_seg7_scanner;

  typedef logic [3:0] bcd_t;

  typedef struct {
    int         tid;
    int         pos;
    logic [4:0] an;
    logic [6:0] seg;
  } exp_t;

`ifdef SEG_LZB_EN
  localparam logic [6:0] LEAD0 = 7'b1111111;
`else
  localparam logic [6:0] LEAD0 = 7'b1000000;
`endif

  logic       clk;
  logic       rst_n;
  bcd_t       D5, D4, D3, D2, D1;
  logic       enable;
  logic [4:0] an;
  logic [6:0] seg;
  logic       frame_done;

  int   checks;
  int   fails;
  int   cyc;
  int   last_fd;
  int   test_id;
  exp_t sb_q[$];

  bcd_seg7_scanner #(
    .REFRESH_DIV (4)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .D5         (D5),
    .D4         (D4),
    .D3         (D3),
    .D2         (D2),
    .D1         (D1),
    .enable     (enable),
    .an         (an),
    .seg        (seg),
    .frame_done (frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %b, expected %b", name, act, exp);
    end
  endtask

  task automatic waitFrameDone(input string name);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!frame_done && n < 200);
    if (!frame_done) begin
      checks++;
      fails++;
      $display("[TB] FAIL %s: frame_done timeout, got 0 after %0d cycles, expected a pulse", name, n);
    end
  endtask

  // Drive digits/enable, wait for the load of those digits, queue the five
  // expected slots of that frame and hold until the frame is almost over.
  task automatic applyStimulus(input string name, input bcd_t d5, input bcd_t d4,
                               input bcd_t d3, input bcd_t d2, input bcd_t d1,
                               input logic en, input logic [4:0][6:0] exp_seg,
                               input logic mid_change, input bcd_t new_d1);
    exp_t e;
    D5 = d5; D4 = d4; D3 = d3; D2 = d2; D1 = d1;
    enable = en;
    test_id++;
    $display("[TB] test %0d: %s", test_id, name);
    waitFrameDone(name);
    for (int k = 0; k < 5; k++) begin
      e.tid = test_id;
      e.pos = k;
      e.an  = en ? ~(5'b00001 << k) : 5'b11111;
      e.seg = en ? exp_seg[k] : 7'b1111111;
      sb_q.push_back(e);
    end
    if (mid_change) begin
      @(negedge clk);
      D1 = new_d1;
      repeat (18) @(negedge clk);
    end else begin
      repeat (19) @(negedge clk);
    end
  endtask

  // Monitor: on each frame_done, check pulse spacing and width, then sample
  // each slot two cycles into its display window.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && frame_done) begin
        if (last_fd != 0) checkOutput("frame_period", 32'(cyc - last_fd), 32'd20);
        last_fd = cyc;
        @(negedge clk);
        checkOutput("frame_done_width", {31'd0, frame_done}, 32'd0);
        @(negedge clk);
        if (sb_q.size() >= 5) begin
          for (int k = 0; k < 5; k++) begin
            e = sb_q.pop_front();
            checkOutput($sformatf("an_t%0d_p%0d", e.tid, e.pos), {27'd0, an}, {27'd0, e.an});
            checkOutput($sformatf("seg_t%0d_p%0d", e.tid, e.pos), {25'd0, seg}, {25'd0, e.seg});
            if (k < 4) repeat (4) @(negedge clk);
          end
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [4:0][6:0] frame1_seg;
    checks  = 0;
    fails   = 0;
    cyc     = 0;
    last_fd = 0;
    test_id = 0;
    rst_n   = 1'b0;
    enable  = 1'b1;
    D5 = 4'd5; D4 = 4'd8; D3 = 4'd0; D2 = 4'd3; D1 = 4'd9;

    repeat (2) @(negedge clk);
    checkOutput("reset_an", {27'd0, an}, {27'd0, 5'b11111});
    checkOutput("reset_seg", {25'd0, seg}, {25'd0, 7'b1111111});
    checkOutput("reset_frame_done", {31'd0, frame_done}, 32'd0);

    // First frame after reset shows the all-zero reset shadow.
    rst_n = 1'b1;
    frame1_seg = {LEAD0, LEAD0, LEAD0, LEAD0, 7'b1000000};
    repeat (2) @(negedge clk);
    for (int k = 0; k < 5; k++) begin
      if (k > 0) repeat (4) @(negedge clk);
      checkOutput($sformatf("frame1_an_p%0d", k), {27'd0, an}, {27'd0, ~(5'b00001 << k)});
      checkOutput($sformatf("frame1_seg_p%0d", k), {25'd0, seg}, {25'd0, frame1_seg[k]});
    end

    applyStimulus("digits 5,8,0,3,9", 4'd5, 4'd8, 4'd0, 4'd3, 4'd9, 1'b1,
                  {7'b0010010, 7'b0000000, 7'b1000000, 7'b0110000, 7'b0010000}, 1'b0, 4'd0);
    applyStimulus("enable low", 4'd5, 4'd8, 4'd0, 4'd3, 4'd9, 1'b0,
                  {7'b0010010, 7'b0000000, 7'b1000000, 7'b0110000, 7'b0010000}, 1'b0, 4'd0);
    applyStimulus("digits 0,0,0,3,2", 4'd0, 4'd0, 4'd0, 4'd3, 4'd2, 1'b1,
                  {LEAD0, LEAD0, 7'b1000000, 7'b0110000, 7'b0100100}, 1'b0, 4'd0);
    applyStimulus("all zero", 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 1'b1,
                  {LEAD0, LEAD0, LEAD0, LEAD0, 7'b1000000}, 1'b0, 4'd0);
    applyStimulus("D1 9 then 2 mid-frame", 4'd5, 4'd8, 4'd0, 4'd3, 4'd9, 1'b1,
                  {7'b0010010, 7'b0000000, 7'b1000000, 7'b0110000, 7'b0010000}, 1'b1, 4'd2);
    applyStimulus("next frame shows D1=2", 4'd5, 4'd8, 4'd0, 4'd3, 4'd2, 1'b1,
                  {7'b0010010, 7'b0000000, 7'b1000000, 7'b0110000, 7'b0100100}, 1'b0, 4'd0);
    applyStimulus("invalid D3=C", 4'd0, 4'd0, 4'hC, 4'd0, 4'd1, 1'b1,
                  {LEAD0, LEAD0, 7'b0111111, 7'b1000000, 7'b1111001}, 1'b0, 4'd0);

    checkOutput("scoreboard_drained", 32'(sb_q.size()), 32'd0);

    // Asynchronous reset in the middle of a cycle where frame_done is high.
    waitFrameDone("async_reset");
    #2;
    rst_n = 1'b0;
    #1;
    last_fd = 0;
    checkOutput("async_reset_an", {27'd0, an}, {27'd0, 5'b11111});
    checkOutput("async_reset_seg", {25'd0, seg}, {25'd0, 7'b1111111});
    checkOutput("async_reset_frame_done", {31'd0, frame_done}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("restart_an", {27'd0, an}, {27'd0, 5'b11110});
    checkOutput("restart_seg", {25'd0, seg}, {25'd0, 7'b1000000});
    repeat (2) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/bcd_seg7_scanner.md
Name: bcd_seg7_scanner

Overview:
- Downstream of the 16-bit-to-BCD converter: consumes its five BCD digits D5..D1 and drives a 5-digit common-anode seven-segment display by time multiplexing.
- One digit is lit per scan slot.
- Digits are captured once per frame into shadow registers, so a frame never shows a mix of old and new values.
- Sits between the binary-to-BCD stage and the board display pins.

Parameters:
- REFRESH_DIV, 50000, clk cycles per digit slot; legal range >= 2; prescaler width is clog2(REFRESH_DIV).
- NUM_DIGITS, 5, fixed digit count; the block is not generic in it.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- D5  in  4  BCD ten-thousands digit from the converter.
- D4  in  4  BCD thousands digit.
- D3  in  4  BCD hundreds digit.
- D2  in  4  BCD tens digit.
- D1  in  4  BCD units digit.
- enable  in  1  display enable; low blanks the whole display.
- an  out  5  anode selects, active-low; an[0] = D1 position, an[4] = D5 position.
- seg  out  7  segments {g,f,e,d,c,b,a}, active-low.
- frame_done  out  1  one-cycle pulse when the shadow registers load (frame boundary).

Behaviour:
- Reset (async assert, sync release): prescaler=0, idx=0, shadow digits=0, an=5'b11111, seg=7'b1111111, frame_done=0.
- Prescaler counts 0..REFRESH_DIV-1 and wraps. tick=1 when prescaler==REFRESH_DIV-1.
- On tick, idx advances 0->1->2->3->4->0. idx k selects position k, where 0=D1 and 4=D5.
- On a tick with idx==4, i.e. the wrap to 0:
  - shadow<=D5..D1 sampled on that edge;
  - frame_done=1 for the following cycle only.
- First frame after reset shows the reset shadow (all zeros).
- Outputs are registered. an/seg reflect the current idx and shadow one cycle after idx changes; an has exactly one bit low when enabled.
- Decode, active-low:
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000
  - invalid BCD 10..15 displays a dash, 0111111.
- enable=0: registered an=11111 and seg=1111111 from the next edge. Prescaler, idx, shadow and frame_done keep running. Re-enable resumes at the current idx with no restart.
- Input changes mid-frame are ignored until the next shadow load.
- Reset mid-frame restores all reset values immediately, independent of clk.

Optional Feature:
- Macro: SEG_LZB_EN (leading-zero blanking).
- Defined: a position k in 4..1 shows blank (1111111) when shadow digit k and all higher shadow digits are 0. Position 0 (D1) is never blanked, so value 0 shows "0". An invalid digit counts as non-zero.
- Undefined: all five positions are always decoded, leading zeros included.

Decomposition:
- Package seg7_pkg holds:
  - localparam segment patterns SEG_0..SEG_9, SEG_DASH, SEG_BLANK;
  - NUM_DIGITS=5;
  - typedef bcd_t (4-bit).
- One combinational sub-module, bcd_seg7_decode: bcd_t in, 7-bit seg out, including the dash for invalid codes.
- The top module holds the prescaler, idx, shadow, LZB logic and output registers.

Test Plan (REFRESH_DIV=4):
- Reset then hold digits 5,8,0,3,9 with enable=1 → frame 1 shows 00000 (LZB off). After frame_done, slots show:
  - an=11110, seg=0010000
  - an=11101, seg=0110000
  - an=11011, seg=1000000
  - an=10111, seg=0000000
  - an=01111, seg=0010010
- Same digits with enable=0 → an=11111, seg=1111111 throughout; frame_done still pulses every 20 cycles.
- Digits 0,0,0,3,2 with SEG_LZB_EN → positions 4 and 3 show 1111111 (an=01111 / 10111); positions 2..0 show 1000000, 0110000, 0100100. Digits all 0 → only D1 shows 1000000.
- Change D1 from 9 to 2 mid-frame → current frame still shows 0010000 at an=11110; the next frame shows 0100100.
- D3=4'hC → position 2 shows 0111111.
- Assert rst_n=0 mid-slot with no clk edge → an=11111, seg=1111111 and frame_done=0 immediately. After release, the scan restarts at an=11110.
